// File: rtl/axis_to_bram_loader.sv
// axis_to_bram_loader: writes one AXI4-Stream frame into the playback BRAM
// from address 0. It reports load completion, the word count and a sticky
// overflow flag for frames that do not fit.
module axis_to_bram_loader #(
    parameter int unsigned BRAM_DEPTH_BITS        = 10,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned BRAM_TDATA_WIDTH       = 64
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tvalid,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready,
    input  logic                                load_start,
    output logic [BRAM_DEPTH_BITS-1:0]          bram_addr,
    output logic [BRAM_TDATA_WIDTH-1:0]         bram_dataout,
    output logic                                bram_en,
    output logic                                bram_we,
    output logic                                load_done,
    output logic                                overflow,
    output logic [BRAM_DEPTH_BITS:0]            word_count
);

    localparam int unsigned CNT_W = BRAM_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'((1 << BRAM_DEPTH_BITS) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      r_state;
    logic                        r_tready;
    logic [BRAM_DEPTH_BITS-1:0]  r_bram_addr;
    logic [BRAM_TDATA_WIDTH-1:0] r_bram_dataout;
    logic                        r_bram_en;
    logic                        r_bram_we;
    logic                        r_load_done;
    logic                        r_overflow;
    logic [CNT_W-1:0]            r_word_count;

    logic w_hs;
    logic w_unused_tstrb;

    // A beat transfers when the source is valid and the loader is ready.
    assign w_hs = s00_axis_tvalid & r_tready;

    // Strobes carry no information here; every beat is a full word.
    assign w_unused_tstrb = ^s00_axis_tstrb;

    // Load FSM with registered stream, BRAM and status outputs.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state        <= S_IDLE;
            r_tready       <= 1'b0;
            r_bram_addr    <= '0;
            r_bram_dataout <= '0;
            r_bram_en      <= 1'b0;
            r_bram_we      <= 1'b0;
            r_load_done    <= 1'b0;
            r_overflow     <= 1'b0;
            r_word_count   <= '0;
        end else begin
            // Write strobes are single-cycle pulses by default.
            r_bram_en <= 1'b0;
            r_bram_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state      <= S_LOAD;
                        r_tready     <= 1'b1;
                        r_word_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_bram_en      <= 1'b1;
                        r_bram_we      <= 1'b1;
                        r_bram_addr    <= r_word_count[BRAM_DEPTH_BITS-1:0];
                        r_bram_dataout <= BRAM_TDATA_WIDTH'(s00_axis_tdata);
                        r_word_count   <= r_word_count + CNT_W'(1);
                        if (s00_axis_tlast) begin
                            r_state     <= S_DONE;
                            r_tready    <= 1'b0;
                            r_load_done <= 1'b1;
                        end else if (r_word_count == LAST_ADDR) begin
                            // BRAM is full but the frame continues: swallow the rest.
                            r_state    <= S_DRAIN;
                            r_overflow <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs && s00_axis_tlast) begin
                        r_state     <= S_DONE;
                        r_tready    <= 1'b0;
                        r_load_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (load_start) begin
                        r_state      <= S_LOAD;
                        r_tready     <= 1'b1;
                        r_load_done  <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_word_count <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tready <= 1'b0;
                end
            endcase
        end
    end

    assign s00_axis_tready = r_tready;
    assign bram_addr       = r_bram_addr;
    assign bram_dataout    = r_bram_dataout;
    assign bram_en         = r_bram_en;
    assign bram_we         = r_bram_we;
    assign load_done       = r_load_done;
    assign overflow        = r_overflow;
    assign word_count      = r_word_count;

endmodule

// File: doc/axis_to_bram_loader.md
Name: axis_to_bram_loader

Overview:
- Upstream feeder for the dual BRAM-to-stream playback stage in the channel sounder.
- Accepts one frame of sounding samples from a DMA over AXI4-Stream slave (64-bit beats) and writes the beats sequentially into the playback BRAM write port, starting at address 0.
- Reports completion and word count to the control logic, so playback starts only after a full, clean load.

Parameters:
- BRAM_DEPTH_BITS, 10, BRAM address width; capacity = 2^BRAM_DEPTH_BITS words.
- C_S00_AXIS_TDATA_WIDTH, 64, input stream data width.
- BRAM_TDATA_WIDTH, 64, BRAM word width; must equal C_S00_AXIS_TDATA_WIDTH.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  sample beat.
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored; all beats treated as full.
- s00_axis_tvalid  in  1  beat valid.
- s00_axis_tlast  in  1  last beat of frame.
- s00_axis_tready  out  1  loader ready.
- load_start  in  1  single-cycle pulse; arms a new load.
- bram_addr  out  BRAM_DEPTH_BITS  write address.
- bram_dataout  out  BRAM_TDATA_WIDTH  write data.
- bram_en  out  1  port enable.
- bram_we  out  1  write enable.
- load_done  out  1  level; frame load complete.
- overflow  out  1  sticky; frame exceeded BRAM capacity.
- word_count  out  BRAM_DEPTH_BITS+1  words written in the last or current load.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State is IDLE.
  - Outputs tready, bram_en, bram_we, load_done and overflow are 0.
  - bram_addr, bram_dataout and word_count are 0.
- Handshake: a beat transfers on a rising edge with tvalid=1 and tready=1.
- tready is a registered output and depends only on state: 1 in LOAD and DRAIN, 0 in IDLE and DONE.
- IDLE:
  - tready=0.
  - load_start=1 -> LOAD; word_count is cleared to 0.
- LOAD:
  - Each handshake writes the beat at address = word_count (pre-increment), then increments word_count.
  - Handshake with tlast=1 -> DONE.
  - Handshake with tlast=0 that writes address 2^BRAM_DEPTH_BITS-1 -> DRAIN, and overflow is set.
  - Handshake with tlast=1 at address 2^BRAM_DEPTH_BITS-1 -> DONE with no overflow (exact fit).
- DRAIN:
  - tready=1; beats are accepted and discarded, with no BRAM write and word_count frozen at 2^BRAM_DEPTH_BITS.
  - Handshake with tlast=1 -> DONE.
- DONE:
  - load_done=1, tready=0.
  - load_start=1 -> LOAD; load_done, overflow and word_count are cleared on the same edge.
- load_start is ignored in LOAD and DRAIN.
- BRAM write timing: bram_addr, bram_dataout, bram_en and bram_we are registered.
  - bram_en=bram_we=1 for exactly one cycle, the cycle after each LOAD handshake; 0 otherwise.
  - Address and data are held between writes.
- Latencies:
  - Handshake to BRAM write: 1 cycle.
  - Final handshake to load_done=1: 1 cycle. The last BRAM write and load_done assert in the same cycle.
- Arithmetic: word_count saturates at 2^BRAM_DEPTH_BITS and never wraps. bram_addr never wraps within a load.
- Gaps: tvalid low for any number of cycles causes no state change.
- A tlast handshake with zero prior beats is legal: it writes one word, giving word_count=1.
- Reset mid-load: immediate return to IDLE with all outputs at reset values. BRAM contents are undefined and the next load restarts at address 0.

Test Plan:
- Bench uses BRAM_DEPTH_BITS=4.
- Normal frame: load_start, then 5 back-to-back beats 0x11..0x55 with tlast on the 5th -> BRAM addresses 0..4 hold 0x11..0x55; we pulses on 5 consecutive cycles; load_done=1 one cycle after the last handshake; word_count=5; overflow=0; tready=0.
- Exact fit: 16 beats with tlast on the 16th -> addresses 0..15 written; word_count=16; overflow=0; load_done=1.
- Overflow: 20 beats with tlast on the 20th -> only addresses 0..15 written, with beats 17..20 absent from BRAM; tready stays 1 through beat 20; overflow=1; word_count=16; load_done=1.
- Throttled source: 4 beats with tvalid low for 3 cycles between beats, and load_start pulsed during LOAD -> 4 writes at addresses 0..3; the load is not restarted; word_count=4.
- Reload and no-arm: after DONE, beats presented without load_start see tready=0 and nothing is written. A subsequent load_start clears load_done, overflow and word_count on the same edge, and the next frame writes from address 0.
- Reset mid-load: assert aresetn=0 after 3 beats -> all outputs 0 asynchronously. After release, a new load of 2 beats gives word_count=2 at addresses 0..1.
